memory_responder: RTL

//  Word-addressed memory at the far end of the CPU memory bus (MAR/MBR_W/MBR_R/write).

---
 rtl/memory_responder_pkg.sv | 32 +++
 rtl/memory_responder_byte_packer.sv | 60 ++++++
 rtl/memory_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/memory_responder_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : memory_responder_pkg                                         |
// | Brief   : Shared types, defaults and helpers for the memory responder  |
// |           and its program-loader byte packer.                          |
// | Revision: 1.0 - initial release                                        |
// +-----------------------------------------------------------------------+
package memory_responder_pkg;

   // Loader state encodings
   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_LOAD  = 2'd1,
      LD_FLUSH = 2'd2
   } ld_state_t;

   localparam int DEFAULT_BITS_DATA = 32;
   localparam int DEFAULT_BITS_ADDR = 16;
   localparam int DEFAULT_DEPTH     = 4096;

   // Number of loader bytes that make up one memory word
   function automatic int bytes_per_word(input int bits_data);
      return bits_data / 8;
   endfunction

   // Width of a counter/index able to address n items (never narrower than 1)
   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/memory_responder_byte_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : memory_responder_byte_packer                                 |
// | Brief   : Little-endian byte-to-word assembler for the program loader. |
// |           Presents the word including the byte accepted this cycle,    |
// |           flags a full word or a zero-padded final partial word.       |
// | Revision: 1.0 - initial release                                        |
// +-----------------------------------------------------------------------+
module memory_responder_byte_packer
   import memory_responder_pkg::*;
#(
   parameter int BITS_DATA = DEFAULT_BITS_DATA
) (
   input  logic                 clk,
   input  logic                 reset,       // asynchronous, active-low
   input  logic                 clear,       // hold the packer empty
   input  logic                 accept,      // a byte is taken this cycle
   input  logic                 last,        // accepted byte ends the image
   input  logic [7:0]           data,
   output logic [BITS_DATA-1:0] word,        // assembly including this byte
   output logic                 word_valid,  // this byte completes a word
   output logic                 flush_pad    // final partial word, zero-padded
);

   localparam int              BPW      = bytes_per_word(BITS_DATA);
   localparam int              IW       = index_width(BPW);
   localparam logic [IW-1:0]   LAST_IDX = IW'(BPW - 1);

   logic [IW-1:0]        idx;
   logic [BITS_DATA-1:0] assembly;
   logic                 final_byte;

   // Bytes above the current index are always zero in the assembly register,
   // so a partial word comes out already padded.
   assign final_byte = (idx == LAST_IDX);
   assign word       = assembly | (BITS_DATA'(data) << {idx, 3'b000});
   assign word_valid = accept & final_byte;
   assign flush_pad  = accept & last & ~final_byte;

   // Byte index and assembly register; emptied on every word hand-off
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx      <= '0;
         assembly <= '0;
      end else if (clear) begin
         idx      <= '0;
         assembly <= '0;
      end else if (accept) begin
         if (word_valid || flush_pad) begin
            idx      <= '0;
            assembly <= '0;
         end else begin
            idx      <= idx + IW'(1);
            assembly <= word;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : memory_responder                                             |
// | Brief   : Word-addressed memory on the CPU MAR/MBR bus with an         |
// |           embedded byte-stream program loader that holds the CPU in    |
// |           reset while it fills memory from address 0.                  |
// | Revision: 1.0 - initial release                                        |
// +-----------------------------------------------------------------------+
module memory_responder
   import memory_responder_pkg::*;
#(
   parameter int BITS_DATA = DEFAULT_BITS_DATA,
   parameter int BITS_ADDR = DEFAULT_BITS_ADDR,
   parameter int DEPTH     = DEFAULT_DEPTH     // must be below 2**BITS_ADDR
) (
   input  logic                 clk,
   input  logic                 reset,      // asynchronous, active-low
   input  logic [BITS_ADDR-1:0] MAR,
   input  logic [BITS_DATA-1:0] MBR_W,
   input  logic                 write,
   output logic [BITS_DATA-1:0] MBR_R,
   input  logic                 ld_start,
   input  logic                 ld_valid,
   input  logic [7:0]           ld_data,
   input  logic                 ld_last,
   output logic                 ld_ready,
   output logic                 cpu_hold,
   output logic [BITS_ADDR-1:0] ld_words,
   output logic                 addr_err
);

   localparam int                   AW      = index_width(DEPTH);
   localparam logic [BITS_ADDR-1:0] DEPTH_A = BITS_ADDR'(DEPTH);

   ld_state_t            state;
   logic [BITS_DATA-1:0] mem [DEPTH];

   logic                 mar_in_range;
   logic                 load_full;
   logic                 accept;
   logic                 commit;
   logic                 load_we;
   logic                 cpu_we;
   logic                 mem_we;
   logic [AW-1:0]        waddr;
   logic [BITS_DATA-1:0] wdata;
   logic [BITS_DATA-1:0] packed_word;
   logic                 word_valid;
   logic                 flush_pad;
   logic                 packer_clear;

   assign mar_in_range = (MAR < DEPTH_A);
   // ld_words doubles as the load address counter; it stops at DEPTH
   assign load_full    = (ld_words == DEPTH_A);
   // ld_ready is only ever high in LD_LOAD
   assign accept       = ld_valid & ld_ready;
   assign commit       = word_valid | flush_pad;
   assign load_we      = commit & ~load_full;
   // CPU stores are only honoured while the loader is idle
   assign cpu_we       = (state == LD_IDLE) & write & mar_in_range;
   // No array update while reset is held, so a reset mid-load loses only
   // the partial word
   assign mem_we       = reset & (load_we | cpu_we);
   assign waddr        = load_we ? ld_words[AW-1:0] : MAR[AW-1:0];
   assign wdata        = load_we ? packed_word : MBR_W;
   assign packer_clear = (state != LD_LOAD);

   memory_responder_byte_packer #(
      .BITS_DATA (BITS_DATA)
   ) u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (packer_clear),
      .accept     (accept),
      .last       (ld_last),
      .data       (ld_data),
      .word       (packed_word),
      .word_valid (word_valid),
      .flush_pad  (flush_pad)
   );

   // Memory array: contents survive reset; the last write edge wins
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[waddr] <= wdata;
      end
   end

   // Combinational read port, silenced during reset, CPU hold and out of range
   always_comb begin
      MBR_R = '0;
      if (reset && !cpu_hold && mar_in_range) begin
         MBR_R = mem[MAR[AW-1:0]];
      end
   end

   // Loader FSM with registered ready/hold/count and sticky error flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= LD_IDLE;
         ld_ready <= 1'b0;
         cpu_hold <= 1'b0;
         ld_words <= '0;
         addr_err <= 1'b0;
      end else begin
         // The CPU only owns the bus while idle; loader bytes past a full
         // memory are swallowed but flagged
         if ((state == LD_IDLE) && !mar_in_range) begin
            addr_err <= 1'b1;
         end
         if (accept && load_full) begin
            addr_err <= 1'b1;
         end

         case (state)
            LD_IDLE: begin
               if (ld_start) begin
                  state    <= LD_LOAD;
                  ld_ready <= 1'b1;
                  cpu_hold <= 1'b1;
                  ld_words <= '0;
               end
            end
            LD_LOAD: begin
               if (load_we) begin
                  ld_words <= ld_words + BITS_ADDR'(1);
               end
               if (accept && ld_last) begin
                  state    <= LD_FLUSH;
                  ld_ready <= 1'b0;
               end
            end
            LD_FLUSH: begin
               state    <= LD_IDLE;
               cpu_hold <= 1'b0;
            end
            default: begin
               state    <= LD_IDLE;
               ld_ready <= 1'b0;
               cpu_hold <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
